// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - shared MIPS core constants for the ID/EX pipeline register
// Contents: opcode/funct encodings of the canonical NOP, the NOP instruction
// word, the Tnew field width and the rs/rt field positions within an
// instruction word, plus small field-extraction helpers.
package cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;

    // sll $0,$0,0 encodes as all zeros.
    localparam logic [31:0] NOP_INSTR = {OP_SPECIAL, 5'd0, 5'd0, 5'd0, 5'd0, FUNCT_SLL};

    localparam int TW = 2;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    function automatic logic [4:0] rs_field(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] rt_field(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - D-stage bundle, W-stage write port and E-stage outputs of the ID/EX register
// Optional: ID_EX_BUBBLE_CNT_EN adds the BubbleCnt observation counter.
// Modports:
//   master - the surrounding pipeline: drives HoldE/ClrE, the D bundle and
//            the W write port; observes the E-stage fields.
//   slave  - the ID/EX register itself.
interface id_ex_reg_if #(
    parameter int DW = 32,
    parameter int TW = 2
);
    logic          HoldE;
    logic          ClrE;

    logic [31:0]   InstrD;
    logic [DW-1:0] PC8D;
    logic [DW-1:0] RD1D;
    logic [DW-1:0] RD2D;
    logic [DW-1:0] ExtD;
    logic [4:0]    A3D;
    logic [TW-1:0] TnewD;

    logic          RegWriteW;
    logic [4:0]    A3W;
    logic [DW-1:0] WDW;

    logic [31:0]   InstrE;
    logic [5:0]    OpE;
    logic [5:0]    FunctE;
    logic [DW-1:0] PC8E;
    logic [DW-1:0] RD1E;
    logic [DW-1:0] RD2E;
    logic [DW-1:0] ExtE;
    logic [4:0]    A3E;
    logic [TW-1:0] TnewE;
    logic          ValidE;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0]   BubbleCnt;
`endif

    modport master (
`ifdef ID_EX_BUBBLE_CNT_EN
        input  BubbleCnt,
`endif
        output HoldE, ClrE,
        output InstrD, PC8D, RD1D, RD2D, ExtD, A3D, TnewD,
        output RegWriteW, A3W, WDW,
        input  InstrE, OpE, FunctE, PC8E, RD1E, RD2E, ExtE, A3E, TnewE, ValidE
    );

    modport slave (
`ifdef ID_EX_BUBBLE_CNT_EN
        output BubbleCnt,
`endif
        input  HoldE, ClrE,
        input  InstrD, PC8D, RD1D, RD2D, ExtD, A3D, TnewD,
        input  RegWriteW, A3W, WDW,
        output InstrE, OpE, FunctE, PC8E, RD1E, RD2E, ExtE, A3E, TnewE, ValidE
    );

endinterface

// File: rtl/id_ex_reg_wt_refresh.sv
// rtl/id_ex_reg_wt_refresh.sv - W-stage write-through compare/mux for one held E-stage operand
// Ports:
//   field     in  5   register number the operand was read from (rs or rt)
//   regwritew in  1   W-stage write enable
//   a3w       in  5   W-stage destination register
//   wdw       in  DW  W-stage write data
//   old_val   in  DW  operand currently held in E
//   new_val   out DW  operand to keep for the next cycle
module wt_refresh #(
    parameter int DW = 32
) (
    input  logic [4:0]    field,
    input  logic          regwritew,
    input  logic [4:0]    a3w,
    input  logic [DW-1:0] wdw,
    input  logic [DW-1:0] old_val,
    output logic [DW-1:0] new_val
);

    logic hit;

    // $0 is hard-wired, so a W write to register 0 never refreshes anything.
    assign hit     = regwritew && (a3w != 5'd0) && (a3w == field);
    assign new_val = hit ? wdw : old_val;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with bubble, hold and W write-through refresh
// Optional: ID_EX_BUBBLE_CNT_EN adds BubbleCnt, a wrapping count of bubbles loaded.
// Ports:
//   clk      in  1   core clock, rising edge
//   reset_n  in  1   asynchronous active-low reset
//   bus      slave modport of id_ex_reg_if:
//            HoldE, ClrE, D bundle (InstrD, PC8D, RD1D, RD2D, ExtD, A3D, TnewD),
//            W write port (RegWriteW, A3W, WDW) in;
//            E bundle (InstrE, OpE, FunctE, PC8E, RD1E, RD2E, ExtE, A3E, TnewE,
//            ValidE[, BubbleCnt]) out.
// Edge priority: HoldE > ClrE > load.
module id_ex_reg #(
    parameter int          DW        = 32,
    parameter int          TW        = cpu_pkg::TW,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset_n,
    id_ex_reg_if.slave bus
);

    import cpu_pkg::*;

    logic [31:0]   instr_e;
    logic [DW-1:0] pc8_e;
    logic [DW-1:0] rd1_e;
    logic [DW-1:0] rd2_e;
    logic [DW-1:0] ext_e;
    logic [4:0]    a3_e;
    logic [TW-1:0] tnew_e;
    logic          valid_e;

    logic [DW-1:0] rd1_ref;
    logic [DW-1:0] rd2_ref;
    logic [TW-1:0] tnew_dec;

    // Held operands can go stale when the producer retires from W while the
    // consumer sits in E; refresh them from the W write port.
    wt_refresh #(.DW(DW)) u_wt_rs (
        .field     (rs_field(instr_e)),
        .regwritew (bus.RegWriteW),
        .a3w       (bus.A3W),
        .wdw       (bus.WDW),
        .old_val   (rd1_e),
        .new_val   (rd1_ref)
    );

    wt_refresh #(.DW(DW)) u_wt_rt (
        .field     (rt_field(instr_e)),
        .regwritew (bus.RegWriteW),
        .a3w       (bus.A3W),
        .wdw       (bus.WDW),
        .old_val   (rd2_e),
        .new_val   (rd2_ref)
    );

    // Tnew counts down while the instruction waits in E; it saturates so a
    // long multi-cycle stall never wraps back to a "not ready" value.
    assign tnew_dec = (tnew_e == '0) ? '0 : tnew_e - TW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_e <= NOP_INSTR;
            pc8_e   <= '0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            ext_e   <= '0;
            a3_e    <= 5'd0;
            tnew_e  <= '0;
            valid_e <= 1'b0;
        end else if (bus.HoldE) begin
            // ClrE is deliberately ignored here; D keeps it asserted until
            // the hold drops.
            tnew_e <= tnew_dec;
            rd1_e  <= rd1_ref;
            rd2_e  <= rd2_ref;
        end else if (bus.ClrE) begin
            // Bubble keeps the PC so EPC/debug still sees where the slot was.
            instr_e <= NOP_INSTR;
            pc8_e   <= bus.PC8D;
            rd1_e   <= '0;
            rd2_e   <= '0;
            ext_e   <= '0;
            a3_e    <= 5'd0;
            tnew_e  <= '0;
            valid_e <= 1'b0;
        end else begin
            // D-stage forwarding already covers W writes on a normal load.
            instr_e <= bus.InstrD;
            pc8_e   <= bus.PC8D;
            rd1_e   <= bus.RD1D;
            rd2_e   <= bus.RD2D;
            ext_e   <= bus.ExtD;
            a3_e    <= bus.A3D;
            tnew_e  <= bus.TnewD;
            valid_e <= 1'b1;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt <= 32'd0;
        end else if (!bus.HoldE && bus.ClrE) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign bus.BubbleCnt = bubble_cnt;
`endif

    assign bus.InstrE = instr_e;
    assign bus.OpE    = instr_e[31:26];
    assign bus.FunctE = instr_e[5:0];
    assign bus.PC8E   = pc8_e;
    assign bus.RD1E   = rd1_e;
    assign bus.RD2E   = rd2_e;
    assign bus.ExtE   = ext_e;
    assign bus.A3E    = a3_e;
    assign bus.TnewE  = tnew_e;
    assign bus.ValidE = valid_e;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - self-checking bench for id_ex_reg
module tb_id_ex_reg;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    id_ex_reg_if #(.DW(32), .TW(2)) bus ();

    id_ex_reg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the E stage.
    logic [31:0] m_instr, m_pc8, m_rd1, m_rd2, m_ext, m_bcnt;
    logic [4:0]  m_a3;
    logic [1:0]  m_tnew;
    logic        m_valid;

    task automatic model_reset();
        m_instr = 32'd0; m_pc8 = 32'd0; m_rd1 = 32'd0; m_rd2 = 32'd0;
        m_ext = 32'd0; m_a3 = 5'd0; m_tnew = 2'd0; m_valid = 1'b0; m_bcnt = 32'd0;
    endtask

    task automatic drive_idle();
        bus.HoldE = 1'b0; bus.ClrE = 1'b0;
        bus.RegWriteW = 1'b0; bus.A3W = 5'd0; bus.WDW = 32'd0;
    endtask

    task automatic rand_d();
        bus.InstrD = $urandom; bus.PC8D = $urandom; bus.RD1D = $urandom;
        bus.RD2D = $urandom; bus.ExtD = $urandom;
        bus.A3D = 5'($urandom_range(0, 31)); bus.TnewD = 2'($urandom_range(0, 3));
    endtask

    // One rising edge: update the reference from the inputs seen at the edge,
    // then settle 1 time unit before the caller samples outputs.
    task automatic tick();
        int rs, rt;
        @(posedge clk);
        if (reset_n) begin
            if (bus.HoldE) begin
                if (m_tnew > 0) m_tnew = m_tnew - 2'd1;
                rs = int'(m_instr / (1 << 21)) % 32;
                rt = int'(m_instr / (1 << 16)) % 32;
                if (bus.RegWriteW && bus.A3W != 0) begin
                    if (int'(bus.A3W) == rs) m_rd1 = bus.WDW;
                    if (int'(bus.A3W) == rt) m_rd2 = bus.WDW;
                end
            end else if (bus.ClrE) begin
                m_instr = 32'd0; m_pc8 = bus.PC8D; m_rd1 = 32'd0; m_rd2 = 32'd0;
                m_ext = 32'd0; m_a3 = 5'd0; m_tnew = 2'd0; m_valid = 1'b0;
                m_bcnt = m_bcnt + 32'd1;
            end else begin
                m_instr = bus.InstrD; m_pc8 = bus.PC8D; m_rd1 = bus.RD1D;
                m_rd2 = bus.RD2D; m_ext = bus.ExtD; m_a3 = bus.A3D;
                m_tnew = bus.TnewD; m_valid = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive_idle(); rand_d();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        n_checks++;
        if ({bus.InstrE, bus.PC8E, bus.RD1E, bus.RD2E, bus.ExtE, bus.A3E, bus.TnewE, bus.ValidE} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: InstrE=%h PC8E=%h RD1E=%h RD2E=%h ExtE=%h A3E=%0d TnewE=%0d ValidE=%b, want all zero",
                     bus.InstrE, bus.PC8E, bus.RD1E, bus.RD2E, bus.ExtE, bus.A3E, bus.TnewE, bus.ValidE);
        end
        rand_d(); bus.A3D = 5'd9; bus.TnewD = 2'd3;
        tick();
        bus.HoldE = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({bus.InstrE, bus.PC8E, bus.RD1E, bus.RD2E, bus.ExtE, bus.A3E, bus.TnewE, bus.ValidE} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: InstrE=%h PC8E=%h A3E=%0d TnewE=%0d ValidE=%b, want all zero immediately",
                     bus.InstrE, bus.PC8E, bus.A3E, bus.TnewE, bus.ValidE);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        bus.HoldE = 1'b0;
        rand_d(); bus.InstrD = 32'h8C43_0004; bus.TnewD = 2'd2;
        tick();
        n_checks++;
        if (bus.OpE !== 6'b100011 || bus.ValidE !== 1'b1 || bus.TnewE !== 2'd2 || bus.InstrE !== 32'h8C43_0004) begin
            n_fail++;
            $display("FAIL first_load_lw: OpE=%b ValidE=%b TnewE=%0d InstrE=%h, want 100011 1 2 8c430004",
                     bus.OpE, bus.ValidE, bus.TnewE, bus.InstrE);
        end
    endtask

    task automatic test_load_bubble();
        logic [31:0] pc;
        drive_idle(); rand_d();
        bus.InstrD = {6'b000000, 5'd4, 5'd5, 5'd6, 5'd0, 6'b100001}; bus.A3D = 5'd6;
        tick();
        n_checks++;
        if (bus.OpE !== 6'b000000 || bus.FunctE !== 6'b100001 || bus.A3E !== 5'd6 || bus.ValidE !== 1'b1) begin
            n_fail++;
            $display("FAIL load_addu: OpE=%b FunctE=%b A3E=%0d ValidE=%b, want 000000 100001 6 1",
                     bus.OpE, bus.FunctE, bus.A3E, bus.ValidE);
        end
        rand_d(); bus.ClrE = 1'b1; pc = bus.PC8D;
        tick();
        bus.ClrE = 1'b0;
        n_checks++;
        if (bus.InstrE !== 32'd0 || bus.A3E !== 5'd0 || bus.ValidE !== 1'b0 || bus.PC8E !== pc ||
            bus.RD1E !== 32'd0 || bus.RD2E !== 32'd0 || bus.ExtE !== 32'd0 || bus.TnewE !== 2'd0) begin
            n_fail++;
            $display("FAIL bubble: InstrE=%h A3E=%0d ValidE=%b PC8E=%h RD1E=%h TnewE=%0d, want 0 0 0 %h 0 0",
                     bus.InstrE, bus.A3E, bus.ValidE, bus.PC8E, bus.RD1E, bus.TnewE, pc);
        end
    endtask

    task automatic test_hold_tnew();
        logic [31:0] saved;
        logic [1:0]  exp_t [3];
        exp_t = '{2'd1, 2'd0, 2'd0};
        drive_idle(); rand_d(); bus.TnewD = 2'd2; saved = bus.InstrD;
        tick();
        n_checks++;
        if (bus.TnewE !== 2'd2) begin
            n_fail++;
            $display("FAIL hold_tnew_load: TnewE=%0d want 2", bus.TnewE);
        end
        bus.HoldE = 1'b1; bus.ClrE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            tick();
            n_checks++;
            if (bus.TnewE !== exp_t[i] || bus.InstrE !== saved || bus.ValidE !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_tnew_%0d: TnewE=%0d InstrE=%h ValidE=%b, want %0d %h 1",
                         i, bus.TnewE, bus.InstrE, bus.ValidE, exp_t[i], saved);
            end
        end
        drive_idle();
    endtask

    task automatic test_write_through();
        drive_idle(); rand_d();
        bus.InstrD = {6'b000000, 5'd5, 5'd5, 5'd7, 5'd0, 6'b100011};
        bus.RD1D = 32'h1111_1111; bus.RD2D = 32'h2222_2222;
        tick();
        bus.HoldE = 1'b1; bus.RegWriteW = 1'b1; bus.A3W = 5'd5; bus.WDW = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if (bus.RD1E !== 32'hDEAD_BEEF || bus.RD2E !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wt_both: RD1E=%h RD2E=%h want deadbeef deadbeef", bus.RD1E, bus.RD2E);
        end
        bus.A3W = 5'd0; bus.WDW = 32'h0BAD_F00D;
        tick();
        n_checks++;
        if (bus.RD1E !== 32'hDEAD_BEEF || bus.RD2E !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wt_a3w_zero: RD1E=%h RD2E=%h want deadbeef deadbeef", bus.RD1E, bus.RD2E);
        end
        bus.RegWriteW = 1'b0; bus.A3W = 5'd5;
        tick();
        n_checks++;
        if (bus.RD1E !== 32'hDEAD_BEEF || bus.RD2E !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wt_no_regwrite: RD1E=%h RD2E=%h want deadbeef deadbeef", bus.RD1E, bus.RD2E);
        end
        // Load with a matching W write: operands come from D, not W.
        bus.HoldE = 1'b0; bus.RegWriteW = 1'b1; bus.A3W = 5'd9; bus.WDW = 32'hCAFE_0001;
        bus.InstrD = {6'b000000, 5'd5, 5'd9, 5'd7, 5'd0, 6'b100011};
        bus.RD1D = 32'h3333_3333; bus.RD2D = 32'h4444_4444;
        tick();
        n_checks++;
        if (bus.RD1E !== 32'h3333_3333 || bus.RD2E !== 32'h4444_4444) begin
            n_fail++;
            $display("FAIL wt_not_on_load: RD1E=%h RD2E=%h want 33333333 44444444", bus.RD1E, bus.RD2E);
        end
        bus.HoldE = 1'b1;
        tick();
        n_checks++;
        if (bus.RD1E !== 32'h3333_3333 || bus.RD2E !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL wt_rt_only: RD1E=%h RD2E=%h want 33333333 cafe0001", bus.RD1E, bus.RD2E);
        end
        drive_idle();
    endtask

    task automatic test_priority();
        logic [31:0] saved;
        drive_idle(); rand_d(); saved = bus.InstrD;
        tick();
        bus.HoldE = 1'b1; bus.ClrE = 1'b1; rand_d();
        tick();
        n_checks++;
        if (bus.InstrE !== saved || bus.ValidE !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_hold_wins: InstrE=%h ValidE=%b want %h 1", bus.InstrE, bus.ValidE, saved);
        end
        bus.HoldE = 1'b0; rand_d(); saved = bus.PC8D;
        tick();
        n_checks++;
        if (bus.InstrE !== 32'd0 || bus.ValidE !== 1'b0 || bus.PC8E !== saved) begin
            n_fail++;
            $display("FAIL prio_bubble: InstrE=%h ValidE=%b PC8E=%h want 0 0 %h", bus.InstrE, bus.ValidE, bus.PC8E, saved);
        end
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_d();
            bus.HoldE = ($urandom_range(0, 9) < 3);
            bus.ClrE = ($urandom_range(0, 9) < 2);
            bus.RegWriteW = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: bus.A3W = m_instr[25:21];
                1: bus.A3W = m_instr[20:16];
                2: bus.A3W = 5'd0;
                default: bus.A3W = 5'($urandom_range(0, 31));
            endcase
            bus.WDW = $urandom;
            tick();
            n_checks++;
            if ({bus.InstrE, bus.PC8E, bus.RD1E, bus.RD2E, bus.ExtE, bus.A3E, bus.TnewE, bus.ValidE} !==
                {m_instr, m_pc8, m_rd1, m_rd2, m_ext, m_a3, m_tnew, m_valid} ||
                bus.OpE !== m_instr[31:26] || bus.FunctE !== m_instr[5:0]) begin
                n_fail++;
                $display("FAIL random_%0d: got I=%h P=%h R1=%h R2=%h X=%h A3=%0d T=%0d V=%b, want I=%h P=%h R1=%h R2=%h X=%h A3=%0d T=%0d V=%b",
                         i, bus.InstrE, bus.PC8E, bus.RD1E, bus.RD2E, bus.ExtE, bus.A3E, bus.TnewE, bus.ValidE,
                         m_instr, m_pc8, m_rd1, m_rd2, m_ext, m_a3, m_tnew, m_valid);
            end
        end
        drive_idle();
    endtask

`ifdef ID_EX_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        drive_idle();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
        n_checks++;
        if (bus.BubbleCnt !== 32'd0) begin
            n_fail++;
            $display("FAIL bcnt_reset: BubbleCnt=%0d want 0", bus.BubbleCnt);
        end
        bus.ClrE = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_d(); tick(); end
        bus.HoldE = 1'b1;
        for (int i = 0; i < 2; i++) begin rand_d(); tick(); end
        bus.HoldE = 1'b0; bus.ClrE = 1'b0; rand_d();
        tick();
        n_checks++;
        if (bus.BubbleCnt !== 32'd3 || bus.BubbleCnt !== m_bcnt) begin
            n_fail++;
            $display("FAIL bcnt_count: BubbleCnt=%0d want 3", bus.BubbleCnt);
        end
    endtask
`endif

    initial begin
        model_reset();
        drive_idle();
        rand_d();
        test_reset();
        test_load_bubble();
        test_hold_tnew();
        test_write_through();
        test_priority();
        test_random();
`ifdef ID_EX_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
